// File: rtl/q_frag_pkg.sv
// Shared types and widths for the Q_FRAG upstream control slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package q_frag_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  typedef enum logic {
    PK_SET = 1'b0,
    PK_RST = 1'b1
  } pulse_kind_t;

  localparam int CNT_W = 8;
  localparam int EVT_W = 8;

  // Saturating increment for the event counter.
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == {EVT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/q_frag_req_sync.sv
// Request synchroniser: STAGES-deep flop chain plus rising-edge detect.
// Latency: input edge to rise pulse is STAGES cycles; rise is high for one cycle.
// Backpressure: none; every synchronised rising edge produces one rise pulse.
//
// Ports:
//   clk    in  sampling clock
//   rst_n  in  async active-low reset, clears chain and edge history
//   req    in  asynchronous request level
//   rise   out one-cycle pulse on a synchronised 0->1 transition
module q_frag_req_sync #(
  parameter int STAGES = 2   // legal range 2..4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], req};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/q_frag_ctrl.sv
// Q_FRAG upstream control: QD select/pipeline, QEN gating, post-reset init clear, QST/QRT pulse issue.
// Latency: QD/QEN 1 cycle; request edge to QST/QRT pulse SYNC_STAGES+1 cycles.
// Backpressure: none; requests arriving while busy are held pending and issued in order (set first).
//
// Optional feature: define Q_FRAG_CTRL_EVT_CNT_EN to build the saturating pulse counter on EVT_CNT;
// otherwise EVT_CNT is tied to zero.
//
// Ports:
//   QCK     in   clock (posedge)
//   QRTN    in   async active-low reset
//   QDS     in   QD source select (1 = QDI, 0 = CZI)
//   QDI     in   routing data
//   CZI     in   C_FRAG combinational output
//   EN_REQ  in   clock-enable request
//   ST_REQ  in   async set request (rising edge)
//   RT_REQ  in   async reset request (rising edge)
//   QD      out  registered data
//   QEN     out  registered enable, only in S_RUN
//   QST     out  registered set pulse
//   QRT     out  registered reset pulse / init clear
//   BUSY    out  high outside S_RUN
//   EVT_CNT out  issued-pulse count (feature build) or 0
module q_frag_ctrl
  import q_frag_pkg::*;
#(
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int INIT_CYCLES = 4,   // 1..255
  parameter int PULSE_LEN   = 2    // 1..15
) (
  input  logic             QCK,
  input  logic             QRTN,
  input  logic             QDS,
  input  logic             QDI,
  input  logic             CZI,
  input  logic             EN_REQ,
  input  logic             ST_REQ,
  input  logic             RT_REQ,
  output logic             QD,
  output logic             QEN,
  output logic             QST,
  output logic             QRT,
  output logic             BUSY,
  output logic [EVT_W-1:0] EVT_CNT
);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  state_t           state;
  pulse_kind_t      kind;
  logic [CNT_W-1:0] cnt;
  logic             pend_st;
  logic             pend_rt;
  logic             st_rise;
  logic             rt_rise;
  logic             want_st;
  logic             want_rt;

  q_frag_req_sync #(.STAGES(SYNC_STAGES)) u_st_sync (
    .clk   (QCK),
    .rst_n (QRTN),
    .req   (ST_REQ),
    .rise  (st_rise)
  );

  q_frag_req_sync #(.STAGES(SYNC_STAGES)) u_rt_sync (
    .clk   (QCK),
    .rst_n (QRTN),
    .req   (RT_REQ),
    .rise  (rt_rise)
  );

  // A fresh edge is acted on in the same cycle it is detected, so the
  // pending flag only matters when the FSM cannot issue right away.
  assign want_st = pend_st | st_rise;
  assign want_rt = pend_rt | rt_rise;

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      QD <= 1'b0;
    end else begin
      QD <= QDS ? QDI : CZI;
    end
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state   <= S_INIT;
      kind    <= PK_SET;
      cnt     <= '0;
      pend_st <= 1'b0;
      pend_rt <= 1'b0;
      QEN     <= 1'b0;
      QST     <= 1'b0;
      QRT     <= 1'b1;
      BUSY    <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          QEN     <= 1'b0;
          pend_st <= pend_st | st_rise;
          pend_rt <= pend_rt | rt_rise;
          if (cnt == INIT_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
            QRT   <= 1'b0;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (want_st) begin
            // Set has priority; a coincident reset edge waits its turn.
            state   <= S_PULSE;
            kind    <= PK_SET;
            cnt     <= '0;
            pend_st <= 1'b0;
            pend_rt <= want_rt;
            QST     <= 1'b1;
            QRT     <= 1'b0;
            QEN     <= 1'b0;
            BUSY    <= 1'b1;
          end else if (want_rt) begin
            state   <= S_PULSE;
            kind    <= PK_RST;
            cnt     <= '0;
            pend_rt <= 1'b0;
            QST     <= 1'b0;
            QRT     <= 1'b1;
            QEN     <= 1'b0;
            BUSY    <= 1'b1;
          end else begin
            // Gate QEN off in the cycle a pulse starts so the flop never
            // sees an enable while QST/QRT is active.
            QEN <= EN_REQ;
          end
        end

        S_PULSE: begin
          QEN <= 1'b0;
          if (kind == PK_RST && st_rise) begin
            // Set pre-empts a running reset pulse: swap in one edge so
            // QST and QRT are never high together.
            kind    <= PK_SET;
            cnt     <= '0;
            QST     <= 1'b1;
            QRT     <= 1'b0;
            pend_rt <= pend_rt | rt_rise;
          end else begin
            pend_st <= pend_st | st_rise;
            pend_rt <= pend_rt | rt_rise;
            if (cnt == PULSE_LAST) begin
              state <= S_RUN;
              QST   <= 1'b0;
              QRT   <= 1'b0;
              BUSY  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= S_INIT;
          cnt   <= '0;
          QEN   <= 1'b0;
          QST   <= 1'b0;
          QRT   <= 1'b1;
          BUSY  <= 1'b1;
        end
      endcase
    end
  end

`ifdef Q_FRAG_CTRL_EVT_CNT_EN
  logic             pulse_start;
  logic [EVT_W-1:0] evt_q;

  assign pulse_start = ((state == S_RUN) && (want_st || want_rt)) ||
                       ((state == S_PULSE) && (kind == PK_RST) && st_rise);

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      evt_q <= '0;
    end else if (pulse_start) begin
      evt_q <= sat_inc(evt_q);
    end
  end

  assign EVT_CNT = evt_q;
`else
  assign EVT_CNT = '0;
`endif

endmodule

// File: tb/tb_q_frag_ctrl.sv
// Directed bench for q_frag_ctrl at default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_q_frag_ctrl;

`ifdef Q_FRAG_CTRL_EVT_CNT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif

  logic       QCK = 1'b0;
  logic       QRTN;
  logic       QDS, QDI, CZI, EN_REQ, ST_REQ, RT_REQ;
  logic       QD, QEN, QST, QRT, BUSY;
  logic [7:0] EVT_CNT;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_evt = 8'd0;

  always #5 QCK = ~QCK;

  q_frag_ctrl dut (
    .QCK     (QCK),
    .QRTN    (QRTN),
    .QDS     (QDS),
    .QDI     (QDI),
    .CZI     (CZI),
    .EN_REQ  (EN_REQ),
    .ST_REQ  (ST_REQ),
    .RT_REQ  (RT_REQ),
    .QD      (QD),
    .QEN     (QEN),
    .QST     (QST),
    .QRT     (QRT),
    .BUSY    (BUSY),
    .EVT_CNT (EVT_CNT)
  );

  task automatic step;
    @(posedge QCK);
    @(negedge QCK);
  endtask

  task automatic test_reset;
    bit e_qrt [1:5] = '{1, 1, 1, 0, 0};
    bit e_qen [1:5] = '{0, 0, 0, 0, 1};
    QRTN = 1'b0; QDS = 0; QDI = 0; CZI = 0; EN_REQ = 0; ST_REQ = 0; RT_REQ = 0;
    exp_evt = 8'd0;
    @(negedge QCK);
    n_cmp++; if (QD !== 1'b0)   begin n_bad++; $display("FAIL reset_qd got %b want 0", QD); end
    n_cmp++; if (QEN !== 1'b0)  begin n_bad++; $display("FAIL reset_qen got %b want 0", QEN); end
    n_cmp++; if (QST !== 1'b0)  begin n_bad++; $display("FAIL reset_qst got %b want 0", QST); end
    n_cmp++; if (QRT !== 1'b1)  begin n_bad++; $display("FAIL reset_qrt got %b want 1", QRT); end
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", BUSY); end
    n_cmp++; if (EVT_CNT !== 8'd0) begin n_bad++; $display("FAIL reset_evt got %0d want 0", EVT_CNT); end
    QRTN = 1'b1;
    EN_REQ = 1'b1;
    #1;
    n_cmp++; if (QRT !== 1'b1) begin n_bad++; $display("FAIL init_qrt k=0 got %b want 1", QRT); end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++; if (QRT !== e_qrt[k])  begin n_bad++; $display("FAIL init_qrt k=%0d got %b want %b", k, QRT, e_qrt[k]); end
      n_cmp++; if (BUSY !== e_qrt[k]) begin n_bad++; $display("FAIL init_busy k=%0d got %b want %b", k, BUSY, e_qrt[k]); end
      n_cmp++; if (QEN !== e_qen[k])  begin n_bad++; $display("FAIL init_qen k=%0d got %b want %b", k, QEN, e_qen[k]); end
    end
    EN_REQ = 1'b0;
    step();
  endtask

  task automatic test_datapath;
    bit pat_c [0:3] = '{0, 1, 1, 0};
    bit pat_q [0:3] = '{1, 0, 0, 1};
    EN_REQ = 1'b1;
    QDS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      CZI = pat_c[i]; QDI = ~pat_c[i];
      step();
      n_cmp++; if (QD !== pat_c[i]) begin n_bad++; $display("FAIL qd_czi i=%0d got %b want %b", i, QD, pat_c[i]); end
      n_cmp++; if (QEN !== 1'b1)    begin n_bad++; $display("FAIL qen_run i=%0d got %b want 1", i, QEN); end
    end
    QDS = 1'b1;
    for (int i = 0; i < 4; i++) begin
      QDI = pat_q[i]; CZI = ~pat_q[i];
      step();
      n_cmp++; if (QD !== pat_q[i]) begin n_bad++; $display("FAIL qd_qdi i=%0d got %b want %b", i, QD, pat_q[i]); end
    end
    EN_REQ = 1'b0;
    step();
    n_cmp++; if (QEN !== 1'b0) begin n_bad++; $display("FAIL qen_off got %b want 0", QEN); end
    QDS = 1'b0; QDI = 1'b0; CZI = 1'b0;
  endtask

  task automatic test_set_pulse;
    bit e_qst  [1:6] = '{0, 0, 1, 1, 0, 0};
    bit e_qen  [1:6] = '{1, 1, 0, 0, 0, 1};
    EN_REQ = 1'b1;
    ST_REQ = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++; if (QST !== e_qst[k])  begin n_bad++; $display("FAIL set_qst k=%0d got %b want %b", k, QST, e_qst[k]); end
      n_cmp++; if (QRT !== 1'b0)      begin n_bad++; $display("FAIL set_qrt k=%0d got %b want 0", k, QRT); end
      n_cmp++; if (QEN !== e_qen[k])  begin n_bad++; $display("FAIL set_qen k=%0d got %b want %b", k, QEN, e_qen[k]); end
      n_cmp++; if (BUSY !== e_qst[k]) begin n_bad++; $display("FAIL set_busy k=%0d got %b want %b", k, BUSY, e_qst[k]); end
    end
    exp_evt = exp_evt + 8'd1;
    n_cmp++; if (EVT_CNT !== (EVT_ON ? exp_evt : 8'd0)) begin n_bad++; $display("FAIL set_evt got %0d want %0d", EVT_CNT, EVT_ON ? exp_evt : 8'd0); end
    ST_REQ = 1'b0;
    EN_REQ = 1'b0;
    step();
  endtask

  task automatic test_simultaneous;
    bit e_qst  [1:9] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    bit e_qrt  [1:9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    ST_REQ = 1'b1;
    RT_REQ = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++; if (QST !== e_qst[k]) begin n_bad++; $display("FAIL both_qst k=%0d got %b want %b", k, QST, e_qst[k]); end
      n_cmp++; if (QRT !== e_qrt[k]) begin n_bad++; $display("FAIL both_qrt k=%0d got %b want %b", k, QRT, e_qrt[k]); end
      n_cmp++; if (BUSY !== (e_qst[k] | e_qrt[k])) begin n_bad++; $display("FAIL both_busy k=%0d got %b want %b", k, BUSY, e_qst[k] | e_qrt[k]); end
    end
    exp_evt = exp_evt + 8'd2;
    n_cmp++; if (EVT_CNT !== (EVT_ON ? exp_evt : 8'd0)) begin n_bad++; $display("FAIL both_evt got %0d want %0d", EVT_CNT, EVT_ON ? exp_evt : 8'd0); end
    ST_REQ = 1'b0;
    RT_REQ = 1'b0;
    step();
  endtask

  task automatic test_preempt;
    bit e_qst  [1:8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    bit e_qrt  [1:8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    RT_REQ = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (QST !== e_qst[k]) begin n_bad++; $display("FAIL pre_qst k=%0d got %b want %b", k, QST, e_qst[k]); end
      n_cmp++; if (QRT !== e_qrt[k]) begin n_bad++; $display("FAIL pre_qrt k=%0d got %b want %b", k, QRT, e_qrt[k]); end
      n_cmp++; if ((QST & QRT) !== 1'b0) begin n_bad++; $display("FAIL pre_excl k=%0d got %b want 0", k, QST & QRT); end
      if (k == 1) ST_REQ = 1'b1;
    end
    exp_evt = exp_evt + 8'd2;
    n_cmp++; if (EVT_CNT !== (EVT_ON ? exp_evt : 8'd0)) begin n_bad++; $display("FAIL pre_evt got %0d want %0d", EVT_CNT, EVT_ON ? exp_evt : 8'd0); end
    ST_REQ = 1'b0;
    RT_REQ = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    bit e_qst [1:9] = '{0, 0, 1, 1, 0, 1, 1, 0, 0};
    ST_REQ = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++; if (QST !== e_qst[k]) begin n_bad++; $display("FAIL b2b_qst k=%0d got %b want %b", k, QST, e_qst[k]); end
      n_cmp++; if (QRT !== 1'b0)     begin n_bad++; $display("FAIL b2b_qrt k=%0d got %b want 0", k, QRT); end
      if (k == 1) ST_REQ = 1'b0;
      if (k == 2) ST_REQ = 1'b1;
    end
    exp_evt = exp_evt + 8'd2;
    n_cmp++; if (EVT_CNT !== (EVT_ON ? exp_evt : 8'd0)) begin n_bad++; $display("FAIL b2b_evt got %0d want %0d", EVT_CNT, EVT_ON ? exp_evt : 8'd0); end
    ST_REQ = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_pulse;
    bit e_qrt [1:8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    ST_REQ = 1'b1;
    for (int k = 1; k <= 3; k++) step();
    n_cmp++; if (QST !== 1'b1) begin n_bad++; $display("FAIL mid_qst_before got %b want 1", QST); end
    ST_REQ = 1'b0;
    QRTN = 1'b0;
    exp_evt = 8'd0;
    #1;
    n_cmp++; if (QST !== 1'b0)  begin n_bad++; $display("FAIL mid_qst_async got %b want 0", QST); end
    n_cmp++; if (QRT !== 1'b1)  begin n_bad++; $display("FAIL mid_qrt_async got %b want 1", QRT); end
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL mid_busy_async got %b want 1", BUSY); end
    n_cmp++; if (EVT_CNT !== 8'd0) begin n_bad++; $display("FAIL mid_evt_async got %0d want 0", EVT_CNT); end
    @(negedge QCK);
    QRTN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (QRT !== e_qrt[k])  begin n_bad++; $display("FAIL reinit_qrt k=%0d got %b want %b", k, QRT, e_qrt[k]); end
      n_cmp++; if (BUSY !== e_qrt[k]) begin n_bad++; $display("FAIL reinit_busy k=%0d got %b want %b", k, BUSY, e_qrt[k]); end
      n_cmp++; if (QST !== 1'b0)      begin n_bad++; $display("FAIL reinit_qst k=%0d got %b want 0", k, QST); end
    end
    n_cmp++; if (EVT_CNT !== 8'd0) begin n_bad++; $display("FAIL reinit_evt got %0d want 0", EVT_CNT); end
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_set_pulse();
    test_simultaneous();
    test_preempt();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
